alu_rs_scheduler: RTL and testbench

//  Reservation station and issue scheduler for the integer ALU in the Tomasulo core.

---
 rtl/alu_rs_scheduler_pkg.sv | 71 +++++++
 rtl/alu_rs_scheduler_if.sv | 52 +++++
 rtl/alu_rs_scheduler_rs_ready_select.sv | 21 ++
 rtl/alu_rs_scheduler.sv | 123 ++++++++++++
 tb/tb_alu_rs_scheduler.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/alu_rs_scheduler_pkg.sv
// Shared definitions for the ALU reservation station: opcodes, sizes, entry layout and wakeup helper.
// Optional feature macro used by the scheduler: ALU_RS_WAKEUP_BYPASS_EN.
package alu_rs_scheduler_pkg;

  localparam int RS_SIZE  = 16;
  localparam int RS_IDX_W = 4;
  localparam int ENTRY_W  = 5;

  localparam logic [ENTRY_W-1:0] RS_ENTRY_NONE = 5'h1f;

  localparam logic [5:0] OP_NOP  = 6'd0;
  localparam logic [5:0] OP_ADD  = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_AND  = 6'd3;
  localparam logic [5:0] OP_OR   = 6'd4;
  localparam logic [5:0] OP_XOR  = 6'd5;
  localparam logic [5:0] OP_SLT  = 6'd6;
  localparam logic [5:0] OP_SLL  = 6'd7;
  localparam logic [5:0] OP_ADDI = 6'd8;
  localparam logic [5:0] OP_LUI  = 6'd9;
  localparam logic [5:0] OP_JAL  = 6'd10;
  localparam logic [5:0] OP_BEQ  = 6'd11;

  typedef struct packed {
    logic               valid;
    logic [5:0]         op;
    logic [31:0]        inst;
    logic [31:0]        vj;
    logic [ENTRY_W-1:0] qj;
    logic               qj_busy;
    logic [31:0]        vk;
    logic [ENTRY_W-1:0] qk;
    logic               qk_busy;
    logic [31:0]        pc;
    logic [31:0]        imm;
    logic [ENTRY_W-1:0] entry;
  } rs_entry_t;

  function automatic rs_entry_t rs_entry_empty();
    rs_entry_t e;
    e    = '0;
    e.qj = RS_ENTRY_NONE;
    e.qk = RS_ENTRY_NONE;
    return e;
  endfunction

  // Capture matching CDB values into pending operands; the ALU broadcast wins a double match.
  function automatic rs_entry_t wake_entry(
    input rs_entry_t          e,
    input logic               alu_v,
    input logic [ENTRY_W-1:0] alu_e,
    input logic [31:0]        alu_val,
    input logic               lsb_v,
    input logic [ENTRY_W-1:0] lsb_e,
    input logic [31:0]        lsb_val
  );
    rs_entry_t r;
    logic      aj, lj, ak, lk;
    r  = e;
    aj = e.qj_busy && alu_v && (alu_e == e.qj);
    lj = e.qj_busy && lsb_v && (lsb_e == e.qj);
    ak = e.qk_busy && alu_v && (alu_e == e.qk);
    lk = e.qk_busy && lsb_v && (lsb_e == e.qk);
    r.vj      = aj ? alu_val : (lj ? lsb_val : e.vj);
    r.qj_busy = e.qj_busy && !aj && !lj;
    r.vk      = ak ? alu_val : (lk ? lsb_val : e.vk);
    r.qk_busy = e.qk_busy && !ak && !lk;
    return r;
  endfunction

endpackage

// File: rtl/alu_rs_scheduler_if.sv
// Dispatch, CDB and issue bundle between the dispatcher/CDB side (master) and the scheduler (slave).
interface alu_rs_scheduler_if;
  import alu_rs_scheduler_pkg::*;

  logic               dispatch_valid;
  logic [31:0]        dispatch_inst;
  logic [5:0]         dispatch_op;
  logic [31:0]        dispatch_vj;
  logic [31:0]        dispatch_vk;
  logic [ENTRY_W-1:0] dispatch_qj;
  logic [ENTRY_W-1:0] dispatch_qk;
  logic               dispatch_qj_busy;
  logic               dispatch_qk_busy;
  logic [31:0]        dispatch_pc;
  logic [31:0]        dispatch_imm;
  logic [ENTRY_W-1:0] dispatch_entry;
  logic               alu_cdb_valid;
  logic [ENTRY_W-1:0] alu_cdb_entry;
  logic [31:0]        alu_cdb_value;
  logic               lsb_cdb_valid;
  logic [ENTRY_W-1:0] lsb_cdb_entry;
  logic [31:0]        lsb_cdb_value;
  logic               rs_full;
  logic               alu_new_calculate;
  logic [31:0]        alu_instruction;
  logic [5:0]         alu_op;
  logic [31:0]        alu_vj;
  logic [31:0]        alu_vk;
  logic [31:0]        alu_pc;
  logic [31:0]        alu_imm;
  logic [ENTRY_W-1:0] alu_entry;

  modport master (
    output dispatch_valid, dispatch_inst, dispatch_op, dispatch_vj, dispatch_vk,
           dispatch_qj, dispatch_qk, dispatch_qj_busy, dispatch_qk_busy,
           dispatch_pc, dispatch_imm, dispatch_entry,
           alu_cdb_valid, alu_cdb_entry, alu_cdb_value,
           lsb_cdb_valid, lsb_cdb_entry, lsb_cdb_value,
    input  rs_full, alu_new_calculate, alu_instruction, alu_op, alu_vj, alu_vk,
           alu_pc, alu_imm, alu_entry
  );

  modport slave (
    input  dispatch_valid, dispatch_inst, dispatch_op, dispatch_vj, dispatch_vk,
           dispatch_qj, dispatch_qk, dispatch_qj_busy, dispatch_qk_busy,
           dispatch_pc, dispatch_imm, dispatch_entry,
           alu_cdb_valid, alu_cdb_entry, alu_cdb_value,
           lsb_cdb_valid, lsb_cdb_entry, lsb_cdb_value,
    output rs_full, alu_new_calculate, alu_instruction, alu_op, alu_vj, alu_vk,
           alu_pc, alu_imm, alu_entry
  );
endinterface

// File: rtl/alu_rs_scheduler_rs_ready_select.sv
// Lowest-index priority encoder over a request vector; shared by issue select and free-slot search.
module rs_ready_select #(
  parameter int N = 16,
  parameter int W = 4
) (
  input  logic [N-1:0] req,
  output logic         found,
  output logic [W-1:0] index
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int i = N - 1; i >= 0; i--) begin
      found = found | req[i];
      index = req[i] ? W'(i) : index;
    end
  end

endmodule

// File: rtl/alu_rs_scheduler.sv
// ALU reservation station: dispatch into free slots, CDB wakeup, one lowest-index issue per cycle.
// Define ALU_RS_WAKEUP_BYPASS_EN to let a dispatching op capture a same-cycle CDB broadcast.
module alu_rs_scheduler
  import alu_rs_scheduler_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rdy,
  input  logic                clear,
  alu_rs_scheduler_if.slave   bus
);

  rs_entry_t             rs_r     [RS_SIZE];
  rs_entry_t             rs_nxt_s [RS_SIZE];
  rs_entry_t             issue_r;
  rs_entry_t             disp_raw_s;
  rs_entry_t             disp_s;
  logic                  new_calc_r;
  logic                  rs_full_r;
  logic [RS_SIZE-1:0]    ready_s;
  logic [RS_SIZE-1:0]    free_s;
  logic [RS_SIZE-1:0]    valid_nxt_s;
  logic                  issue_found_s;
  logic [RS_IDX_W-1:0]   issue_idx_s;
  logic                  free_found_s;
  logic [RS_IDX_W-1:0]   free_idx_s;
  logic                  disp_ok_s;

  // Ready and free vectors from registered state.
  always_comb begin
    ready_s = '0;
    free_s  = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      ready_s[i] = rs_r[i].valid && !rs_r[i].qj_busy && !rs_r[i].qk_busy;
      free_s[i]  = !rs_r[i].valid;
    end
  end

  rs_ready_select #(.N(RS_SIZE), .W(RS_IDX_W)) u_issue_sel (
    .req(ready_s), .found(issue_found_s), .index(issue_idx_s)
  );

  rs_ready_select #(.N(RS_SIZE), .W(RS_IDX_W)) u_free_sel (
    .req(free_s), .found(free_found_s), .index(free_idx_s)
  );

  // Incoming entry, optionally woken by a broadcast in the same cycle.
  always_comb begin
    disp_raw_s         = rs_entry_empty();
    disp_raw_s.valid   = 1'b1;
    disp_raw_s.op      = bus.dispatch_op;
    disp_raw_s.inst    = bus.dispatch_inst;
    disp_raw_s.vj      = bus.dispatch_vj;
    disp_raw_s.qj      = bus.dispatch_qj;
    disp_raw_s.qj_busy = bus.dispatch_qj_busy;
    disp_raw_s.vk      = bus.dispatch_vk;
    disp_raw_s.qk      = bus.dispatch_qk;
    disp_raw_s.qk_busy = bus.dispatch_qk_busy;
    disp_raw_s.pc      = bus.dispatch_pc;
    disp_raw_s.imm     = bus.dispatch_imm;
    disp_raw_s.entry   = bus.dispatch_entry;
`ifdef ALU_RS_WAKEUP_BYPASS_EN
    disp_s = wake_entry(disp_raw_s, bus.alu_cdb_valid, bus.alu_cdb_entry, bus.alu_cdb_value,
                        bus.lsb_cdb_valid, bus.lsb_cdb_entry, bus.lsb_cdb_value);
`else
    disp_s = disp_raw_s;
`endif
    disp_ok_s = bus.dispatch_valid && free_found_s;
  end

  // Per-entry next state: wakeup, then issue invalidation or dispatch write.
  always_comb begin
    valid_nxt_s = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      rs_nxt_s[i] = wake_entry(rs_r[i], bus.alu_cdb_valid, bus.alu_cdb_entry, bus.alu_cdb_value,
                               bus.lsb_cdb_valid, bus.lsb_cdb_entry, bus.lsb_cdb_value);
      if (issue_found_s && (issue_idx_s == RS_IDX_W'(i))) begin
        rs_nxt_s[i].valid = 1'b0;
      end else if (disp_ok_s && (free_idx_s == RS_IDX_W'(i))) begin
        rs_nxt_s[i] = disp_s;
      end else begin
        rs_nxt_s[i].valid = rs_r[i].valid;
      end
      valid_nxt_s[i] = rs_nxt_s[i].valid;
    end
  end

  // State and issue registers; freeze on !rdy, flush on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RS_SIZE; i++) rs_r[i] <= rs_entry_empty();
      issue_r    <= '0;
      new_calc_r <= 1'b0;
      rs_full_r  <= 1'b0;
    end else if (!rdy) begin
      new_calc_r <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < RS_SIZE; i++) rs_r[i] <= rs_entry_empty();
      new_calc_r <= 1'b0;
      rs_full_r  <= 1'b0;
    end else begin
      rs_r      <= rs_nxt_s;
      rs_full_r <= &valid_nxt_s;
      if (issue_found_s) begin
        issue_r    <= rs_r[issue_idx_s];
        new_calc_r <= 1'b1;
      end else begin
        new_calc_r <= 1'b0;
      end
    end
  end

  assign bus.rs_full           = rs_full_r;
  assign bus.alu_new_calculate = new_calc_r;
  assign bus.alu_instruction   = issue_r.inst;
  assign bus.alu_op            = issue_r.op;
  assign bus.alu_vj            = issue_r.vj;
  assign bus.alu_vk            = issue_r.vk;
  assign bus.alu_pc            = issue_r.pc;
  assign bus.alu_imm           = issue_r.imm;
  assign bus.alu_entry         = issue_r.entry;

endmodule

// File: tb/tb_alu_rs_scheduler.sv
// Directed self-checking bench for alu_rs_scheduler (honours ALU_RS_WAKEUP_BYPASS_EN when defined).
module tb_alu_rs_scheduler;
  import alu_rs_scheduler_pkg::*;

  logic clk;
  logic rst_n;
  logic rdy;
  logic clear;
  int   n_checks;
  int   n_fail;
  int   n_issue;

  alu_rs_scheduler_if bus ();

  alu_rs_scheduler dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .clear(clear), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cdb_idle();
    bus.alu_cdb_valid = 1'b0;
    bus.alu_cdb_entry = 5'd0;
    bus.alu_cdb_value = 32'd0;
    bus.lsb_cdb_valid = 1'b0;
    bus.lsb_cdb_entry = 5'd0;
    bus.lsb_cdb_value = 32'd0;
  endtask

  task automatic dispatch_op(input logic [5:0] op, input logic [31:0] vj, input logic [31:0] vk,
                             input logic [4:0] qj, input logic qjb, input logic [4:0] qk,
                             input logic qkb, input logic [4:0] dest);
    bus.dispatch_valid   = 1'b1;
    bus.dispatch_op      = op;
    bus.dispatch_inst    = {26'h0a5a5a5, op};
    bus.dispatch_vj      = vj;
    bus.dispatch_vk      = vk;
    bus.dispatch_qj      = qj;
    bus.dispatch_qj_busy = qjb;
    bus.dispatch_qk      = qk;
    bus.dispatch_qk_busy = qkb;
    bus.dispatch_pc      = 32'h1000 + {27'd0, dest};
    bus.dispatch_imm     = 32'hffff_fff0;
    bus.dispatch_entry   = dest;
    tick();
    bus.dispatch_valid   = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    rdy      = 1'b1;
    clear    = 1'b0;
    bus.dispatch_valid = 1'b0;
    bus.dispatch_op = 6'd0; bus.dispatch_inst = 32'd0; bus.dispatch_vj = 32'd0;
    bus.dispatch_vk = 32'd0; bus.dispatch_qj = 5'd0; bus.dispatch_qk = 5'd0;
    bus.dispatch_qj_busy = 1'b0; bus.dispatch_qk_busy = 1'b0; bus.dispatch_pc = 32'd0;
    bus.dispatch_imm = 32'd0; bus.dispatch_entry = 5'd0;
    cdb_idle();
    tick();
    tick();
    check_val("reset_full", {31'd0, bus.rs_full}, 32'd0);
    check_val("reset_strobe", {31'd0, bus.alu_new_calculate}, 32'd0);
    check_val("reset_vj", bus.alu_vj, 32'd0);
    check_val("reset_entry", {27'd0, bus.alu_entry}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ADD with both operands ready issues one edge after dispatch, strobe for one cycle.
    dispatch_op(OP_ADD, 32'd5, 32'd7, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4);
    check_val("add_not_yet", {31'd0, bus.alu_new_calculate}, 32'd0);
    tick();
    check_val("add_strobe", {31'd0, bus.alu_new_calculate}, 32'd1);
    check_val("add_op", {26'd0, bus.alu_op}, {26'd0, OP_ADD});
    check_val("add_vj", bus.alu_vj, 32'd5);
    check_val("add_vk", bus.alu_vk, 32'd7);
    check_val("add_inst", bus.alu_instruction, {26'h0a5a5a5, OP_ADD});
    check_val("add_pc", bus.alu_pc, 32'h1004);
    check_val("add_entry", {27'd0, bus.alu_entry}, 32'd4);
    tick();
    check_val("add_strobe_drop", {31'd0, bus.alu_new_calculate}, 32'd0);

    // SUB waits on tag 3 until an ALU broadcast, then issues on the following edge.
    dispatch_op(OP_SUB, 32'd0, 32'd2, 5'd3, 1'b1, 5'd0, 1'b0, 5'd1);
    tick();
    check_val("sub_blocked", {31'd0, bus.alu_new_calculate}, 32'd0);
    bus.alu_cdb_valid = 1'b1; bus.alu_cdb_entry = 5'd3; bus.alu_cdb_value = 32'h10;
    tick();
    cdb_idle();
    check_val("sub_wake_edge", {31'd0, bus.alu_new_calculate}, 32'd0);
    tick();
    check_val("sub_strobe", {31'd0, bus.alu_new_calculate}, 32'd1);
    check_val("sub_vj", bus.alu_vj, 32'h10);
    check_val("sub_op", {26'd0, bus.alu_op}, {26'd0, OP_SUB});
    check_val("sub_vk", bus.alu_vk, 32'd2);

    // Fill all 16 slots with blocked ops (entry i waits on tag i), then wake slot 9.
    for (int i = 0; i < 16; i++) begin
      if (i == 15) check_val("full_at_15", {31'd0, bus.rs_full}, 32'd0);
      dispatch_op(OP_AND, 32'd0, 32'(i), 5'(i), 1'b1, 5'd0, 1'b0, 5'(i));
    end
    check_val("full_at_16", {31'd0, bus.rs_full}, 32'd1);
    bus.lsb_cdb_valid = 1'b1; bus.lsb_cdb_entry = 5'd9; bus.lsb_cdb_value = 32'h99;
    tick();
    cdb_idle();
    check_val("full_after_wake", {31'd0, bus.rs_full}, 32'd1);
    tick();
    check_val("wake9_strobe", {31'd0, bus.alu_new_calculate}, 32'd1);
    check_val("wake9_entry", {27'd0, bus.alu_entry}, 32'd9);
    check_val("wake9_vj", bus.alu_vj, 32'h99);
    check_val("wake9_vk", bus.alu_vk, 32'd9);
    check_val("full_released", {31'd0, bus.rs_full}, 32'd0);
    do_clear();

    // Slots 2 and 6 wake together; lowest index goes first.
    for (int i = 0; i < 8; i++) begin
      dispatch_op(OP_ADD, 32'd0, 32'(i), ((i == 2) || (i == 6)) ? 5'd5 : 5'(i + 8), 1'b1,
                  5'd0, 1'b0, 5'(i));
    end
    bus.alu_cdb_valid = 1'b1; bus.alu_cdb_entry = 5'd5; bus.alu_cdb_value = 32'h55;
    tick();
    cdb_idle();
    tick();
    check_val("prio_first", {27'd0, bus.alu_entry}, 32'd2);
    check_val("prio_first_strobe", {31'd0, bus.alu_new_calculate}, 32'd1);
    tick();
    check_val("prio_second", {27'd0, bus.alu_entry}, 32'd6);
    check_val("prio_second_strobe", {31'd0, bus.alu_new_calculate}, 32'd1);
    tick();
    check_val("prio_done", {31'd0, bus.alu_new_calculate}, 32'd0);
    do_clear();

    // Clear flushes pending ops and drops a same-edge dispatch.
    for (int i = 0; i < 5; i++) dispatch_op(OP_OR, 32'd0, 32'd0, 5'(10 + i), 1'b1, 5'd0, 1'b0, 5'(i));
    clear = 1'b1;
    dispatch_op(OP_XOR, 32'd1, 32'd1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd15);
    clear = 1'b0;
    check_val("clear_full", {31'd0, bus.rs_full}, 32'd0);
    check_val("clear_strobe", {31'd0, bus.alu_new_calculate}, 32'd0);
    bus.alu_cdb_valid = 1'b1; bus.alu_cdb_entry = 5'd10; bus.alu_cdb_value = 32'h1;
    tick();
    cdb_idle();
    n_issue = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_issue += int'(bus.alu_new_calculate);
    end
    check_val("clear_no_issue", 32'(n_issue), 32'd0);

    // rdy=0 freezes issue and holds the data registers.
    dispatch_op(OP_OR, 32'hf0, 32'h0f, 5'd0, 1'b0, 5'd0, 1'b0, 5'd2);
    rdy = 1'b0;
    tick();
    check_val("freeze_strobe", {31'd0, bus.alu_new_calculate}, 32'd0);
    check_val("freeze_hold", {27'd0, bus.alu_entry}, 32'd6);
    rdy = 1'b1;
    tick();
    check_val("unfreeze_strobe", {31'd0, bus.alu_new_calculate}, 32'd1);
    check_val("unfreeze_op", {26'd0, bus.alu_op}, {26'd0, OP_OR});
    check_val("unfreeze_vj", bus.alu_vj, 32'hf0);

    // Both CDBs hit the same tag: ALU value wins.
    dispatch_op(OP_SLT, 32'd0, 32'd1, 5'd4, 1'b1, 5'd0, 1'b0, 5'd3);
    bus.alu_cdb_valid = 1'b1; bus.alu_cdb_entry = 5'd4; bus.alu_cdb_value = 32'h111;
    bus.lsb_cdb_valid = 1'b1; bus.lsb_cdb_entry = 5'd4; bus.lsb_cdb_value = 32'h222;
    tick();
    cdb_idle();
    tick();
    check_val("dual_cdb_strobe", {31'd0, bus.alu_new_calculate}, 32'd1);
    check_val("dual_cdb_vj", bus.alu_vj, 32'h111);

    // Dispatch while the LSB broadcasts the awaited tag.
    bus.lsb_cdb_valid = 1'b1; bus.lsb_cdb_entry = 5'd7; bus.lsb_cdb_value = 32'hab;
    dispatch_op(OP_XOR, 32'd0, 32'd0, 5'd7, 1'b1, 5'd0, 1'b0, 5'd5);
    cdb_idle();
`ifdef ALU_RS_WAKEUP_BYPASS_EN
    tick();
    check_val("bypass_strobe", {31'd0, bus.alu_new_calculate}, 32'd1);
    check_val("bypass_vj", bus.alu_vj, 32'hab);
`else
    n_issue = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      n_issue += int'(bus.alu_new_calculate);
    end
    check_val("nobypass_waits", 32'(n_issue), 32'd0);
`endif
    do_clear();

    // Asynchronous reset mid-issue clears outputs without a clock edge.
    dispatch_op(OP_ADD, 32'd1, 32'd2, 5'd0, 1'b0, 5'd0, 1'b0, 5'd8);
    tick();
    check_val("pre_rst_strobe", {31'd0, bus.alu_new_calculate}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_strobe", {31'd0, bus.alu_new_calculate}, 32'd0);
    check_val("async_rst_vj", bus.alu_vj, 32'd0);
    check_val("async_rst_entry", {27'd0, bus.alu_entry}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    check_val("post_rst_idle", {31'd0, bus.alu_new_calculate}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
